// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared constants and types for the two-requester round-robin arbiter.
// Source encoding, default widths and output-stage state.
package mux2_rr_arbiter_pkg;

  localparam logic SRC_A = 1'b1;
  localparam logic SRC_B = 1'b0;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Bundle of requester A/B, output stage and counter signals.
// slave: arbiter view; master: producers/consumer view.
interface mux2_rr_arbiter_if
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              sel;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              out_ready;
  logic [CNT_W-1:0]  cnt_a;
  logic [CNT_W-1:0]  cnt_b;

  modport slave (
    input  a_valid, a_data,
    input  b_valid, b_data,
    input  out_ready,
    output a_ready, b_ready, sel,
    output out_valid, out_data, out_src,
    output cnt_a, cnt_b
  );

  modport master (
    output a_valid, a_data,
    output b_valid, b_data,
    output out_ready,
    input  a_ready, b_ready, sel,
    input  out_valid, out_data, out_src,
    input  cnt_a, cnt_b
  );

endinterface

// File: rtl/mux2_rr_arbiter_pick.sv
// Two-way round-robin pick: last_a_i=0 favours A on conflict.
// Ports: a_valid_i, b_valid_i, last_a_i, en_i -> grant_a_o, grant_b_o.
module rr_pick2 (
  input  logic a_valid_i,
  input  logic b_valid_i,
  input  logic last_a_i,
  input  logic en_i,
  output logic grant_a_o,
  output logic grant_b_o
);

  logic pick_a;

  // A wins when alone, or on conflict when B went last
  assign pick_a    = a_valid_i & (~b_valid_i | ~last_a_i);
  assign grant_a_o = en_i & pick_a;
  assign grant_b_o = en_i & b_valid_i & ~pick_a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin 2:1 arbiter with one-entry registered output stage.
// Ports: clk, rst_n, bus (slave: A/B requests, out_*, cnt_a/cnt_b).
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  mux2_rr_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              src_q, src_d;
  logic              last_a_q, last_a_d;
  logic [CNT_W-1:0]  cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;

  logic out_valid;
  logic can_load;
  logic grant_a;
  logic grant_b;
  logic grant;

  assign can_load = ~out_valid | bus.out_ready;
  assign grant    = grant_a | grant_b;

  rr_pick2 u_pick (
    .a_valid_i (bus.a_valid),
    .b_valid_i (bus.b_valid),
    .last_a_i  (last_a_q),
    .en_i      (can_load),
    .grant_a_o (grant_a),
    .grant_b_o (grant_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      src_q    <= SRC_B;
      last_a_q <= 1'b0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      src_q    <= src_d;
      last_a_q <= last_a_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (grant) state_d = FULL;
      FULL:  if (bus.out_ready && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == FULL);
  end

  always_comb begin
    data_d   = data_q;
    src_d    = src_q;
    last_a_d = last_a_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    if (grant) begin
      data_d   = grant_a ? bus.a_data : bus.b_data;
      src_d    = grant_a ? SRC_A : SRC_B;
      last_a_d = grant_a;
    end
    if (grant_a) cnt_a_d = cnt_a_q + CNT_W'(1);
    if (grant_b) cnt_b_d = cnt_b_q + CNT_W'(1);
  end

  assign bus.a_ready   = grant_a;
  assign bus.b_ready   = grant_b;
  assign bus.sel       = grant_a;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign bus.cnt_a     = cnt_a_q;
  assign bus.cnt_b     = cnt_b_q;

endmodule
